// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Divide/remainder sequencer: holds the instruction in E while the
// iterative divider runs, then releases it for exactly one DONE cycle.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic divE,
  input  logic pcSrcE,
  output logic mdStart,
  output logic mdBusy,
  output logic mdDone,
  output logic holdE
);

  md_state_t              state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   start_c, busy_c, done_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (divE && !pcSrcE) begin
          start_c   = 1'b1;
          cnt_nxt   = CNT_WIDTH'(MDU_LATENCY - 1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_WIDTH'(1);
      end
      DONE: begin
        // Always return to IDLE so the same instruction is not relaunched.
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mdStart = start_c && !rst;
  assign mdBusy  = busy_c  && !rst;
  assign mdDone  = done_c  && !rst;
  assign holdE   = (start_c || busy_c) && !rst;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage RV32IM pipeline.
// Define HAZARD_FWD_EN to enable E-stage operand forwarding; otherwise RAW hazards stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned RF_WIDTH    = 5,
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RF_WIDTH-1:0] regAddr1D,
  input  logic [RF_WIDTH-1:0] regAddr2D,
  input  logic [RF_WIDTH-1:0] regAddr1E,
  input  logic [RF_WIDTH-1:0] regAddr2E,
  input  logic [RF_WIDTH-1:0] regAddr3E,
  input  logic                regWriteE,
  input  logic                loadE,
  input  logic                divE,
  input  logic                pcSrcE,
  input  logic [RF_WIDTH-1:0] regAddr3M,
  input  logic [RF_WIDTH-1:0] regAddr3W,
  input  logic                regWriteM,
  input  logic                regWriteW,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                flushD,
  output logic                flushE,
  output logic                flushM,
  output logic [1:0]          fwdAE,
  output logic [1:0]          fwdBE,
  output logic                mdStart,
  output logic                mdBusy,
  output logic                mdDone
);

`ifdef HAZARD_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic       hold_e;
  logic       wr_e, wr_m, wr_w;
  logic       d_hits_e, d_hits_m;
  logic       lw_stall, raw_stall, data_stall;
  logic [1:0] fwd_a, fwd_b;

  mdu_seq #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_mdu_seq (
    .clk     (clk),
    .rst     (rst),
    .divE    (divE),
    .pcSrcE  (pcSrcE),
    .mdStart (mdStart),
    .mdBusy  (mdBusy),
    .mdDone  (mdDone),
    .holdE   (hold_e)
  );

  assign wr_e = regWriteE && (regAddr3E != '0);
  assign wr_m = regWriteM && (regAddr3M != '0);
  assign wr_w = regWriteW && (regAddr3W != '0);

  assign fwd_a = fwd_sel(wr_m && (regAddr3M == regAddr1E), wr_w && (regAddr3W == regAddr1E));
  assign fwd_b = fwd_sel(wr_m && (regAddr3M == regAddr2E), wr_w && (regAddr3W == regAddr2E));

  assign d_hits_e = wr_e && ((regAddr3E == regAddr1D) || (regAddr3E == regAddr2D));
  assign d_hits_m = wr_m && ((regAddr3M == regAddr1D) || (regAddr3M == regAddr2D));

  assign lw_stall  = loadE && !divE && d_hits_e;
  assign raw_stall = !FWD_ON && (d_hits_e || d_hits_m);
  // A bubble into D/E must never overwrite a divide being held in E.
  assign data_stall = (lw_stall || raw_stall) && !hold_e;

  assign fwdAE  = FWD_ON ? fwd_a : FWD_RF;
  assign fwdBE  = FWD_ON ? fwd_b : FWD_RF;

  assign stallF = !rst && ((data_stall && !pcSrcE) || hold_e);
  assign stallD = !rst && ((data_stall && !pcSrcE) || hold_e);
  assign stallE = hold_e;
  assign flushD = !rst && pcSrcE;
  assign flushE = !rst && (pcSrcE || data_stall);
  assign flushM = hold_e;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl (MDU_LATENCY=4), plus divider sequences.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam logic F = 1'b1;
`else
  localparam logic F = 1'b0;
`endif
  localparam logic [1:0] FM = F ? 2'b10 : 2'b00;
  localparam logic [1:0] FW = F ? 2'b01 : 2'b00;
  localparam logic       NS = !F;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] regAddr1D, regAddr2D, regAddr1E, regAddr2E, regAddr3E, regAddr3M, regAddr3W;
  logic       regWriteE, loadE, divE, pcSrcE, regWriteM, regWriteW;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] fwdAE, fwdBE;
  logic       mdStart, mdBusy, mdDone;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(
    .RF_WIDTH    (5),
    .MDU_LATENCY (4),
    .CNT_WIDTH   (3)
  ) dut (
    .clk(clk), .rst(rst),
    .regAddr1D(regAddr1D), .regAddr2D(regAddr2D),
    .regAddr1E(regAddr1E), .regAddr2E(regAddr2E), .regAddr3E(regAddr3E),
    .regWriteE(regWriteE), .loadE(loadE), .divE(divE), .pcSrcE(pcSrcE),
    .regAddr3M(regAddr3M), .regAddr3W(regAddr3W),
    .regWriteM(regWriteM), .regWriteW(regWriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .fwdAE(fwdAE), .fwdBE(fwdBE),
    .mdStart(mdStart), .mdBusy(mdBusy), .mdDone(mdDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a1D, a2D, a1E, a2E, a3E, a3M, a3W;
    logic       wE, ldE, pc, wM, wW;
    logic       sF, sD, fD, fE;
    logic [1:0] fA, fB;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {regAddr1D, regAddr2D, regAddr1E, regAddr2E, regAddr3E, regAddr3M, regAddr3W} = '0;
    {regWriteE, loadE, divE, pcSrcE, regWriteM, regWriteW} = '0;
  endtask

  task automatic check_div(input string tag, input logic st, input logic bz, input logic dn,
                           input logic hold);
    check({tag, " mdStart"}, {7'd0, mdStart}, {7'd0, st});
    check({tag, " mdBusy"},  {7'd0, mdBusy},  {7'd0, bz});
    check({tag, " mdDone"},  {7'd0, mdDone},  {7'd0, dn});
    check({tag, " stallE"},  {7'd0, stallE},  {7'd0, hold});
    check({tag, " stallF"},  {7'd0, stallF},  {7'd0, hold});
    check({tag, " flushM"},  {7'd0, flushM},  {7'd0, hold});
  endtask

  initial begin
    //        a1D a2D a1E a2E a3E a3M a3W  wE ldE pc wM wW   sF  sD  fD  fE   fA     fB
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,   0,  0,  0,  0,  2'b00, 2'b00};
    vecs[1]  = '{1, 2, 5, 0, 0, 5, 5,      0, 0, 0, 1, 1,   0,  0,  0,  0,  FM,    2'b00};
    vecs[2]  = '{1, 2, 5, 0, 0, 0, 5,      0, 0, 0, 1, 1,   0,  0,  0,  0,  FW,    2'b00};
    vecs[3]  = '{0, 0, 3, 9, 0, 0, 9,      0, 0, 0, 0, 1,   0,  0,  0,  0,  2'b00, FW};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 1,   0,  0,  0,  0,  2'b00, 2'b00};
    vecs[5]  = '{3, 7, 0, 0, 7, 0, 0,      1, 1, 0, 0, 0,   1,  1,  0,  1,  2'b00, 2'b00};
    vecs[6]  = '{3, 7, 0, 0, 0, 0, 0,      1, 1, 0, 0, 0,   0,  0,  0,  0,  2'b00, 2'b00};
    vecs[7]  = '{3, 7, 0, 0, 7, 0, 0,      1, 1, 1, 0, 0,   0,  0,  1,  1,  2'b00, 2'b00};
    vecs[8]  = '{3, 7, 0, 0, 7, 0, 0,      0, 1, 0, 0, 0,   0,  0,  0,  0,  2'b00, 2'b00};
    vecs[9]  = '{4, 0, 0, 0, 4, 0, 0,      1, 0, 0, 0, 0,   NS, NS, 0,  NS, 2'b00, 2'b00};
    vecs[10] = '{0, 6, 0, 0, 0, 6, 0,      0, 0, 0, 1, 0,   NS, NS, 0,  NS, 2'b00, 2'b00};
    vecs[11] = '{8, 0, 0, 0, 0, 0, 8,      0, 0, 0, 0, 1,   0,  0,  0,  0,  2'b00, 2'b00};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0,   0,  0,  1,  1,  2'b00, 2'b00};
    vecs[13] = '{0, 0, 5, 5, 0, 5, 5,      0, 0, 0, 1, 1,   0,  0,  0,  0,  FM,    FM};

    // Reset: stall/flush outputs held low even with a load-use hazard and branch present.
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    regAddr2D = 5'd7; regAddr3E = 5'd7; regWriteE = 1'b1; loadE = 1'b1; pcSrcE = 1'b1; divE = 1'b1;
    #1;
    check("rst stallF", {7'd0, stallF}, 8'd0);
    check("rst stallD", {7'd0, stallD}, 8'd0);
    check("rst flushD", {7'd0, flushD}, 8'd0);
    check("rst flushE", {7'd0, flushE}, 8'd0);
    check_div("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      regAddr1D = vecs[i].a1D; regAddr2D = vecs[i].a2D;
      regAddr1E = vecs[i].a1E; regAddr2E = vecs[i].a2E; regAddr3E = vecs[i].a3E;
      regAddr3M = vecs[i].a3M; regAddr3W = vecs[i].a3W;
      regWriteE = vecs[i].wE; loadE = vecs[i].ldE; pcSrcE = vecs[i].pc;
      regWriteM = vecs[i].wM; regWriteW = vecs[i].wW;
      #1;
      check($sformatf("v%0d stallF", i), {7'd0, stallF}, {7'd0, vecs[i].sF});
      check($sformatf("v%0d stallD", i), {7'd0, stallD}, {7'd0, vecs[i].sD});
      check($sformatf("v%0d flushD", i), {7'd0, flushD}, {7'd0, vecs[i].fD});
      check($sformatf("v%0d flushE", i), {7'd0, flushE}, {7'd0, vecs[i].fE});
      check($sformatf("v%0d fwdAE", i),  {6'd0, fwdAE},  {6'd0, vecs[i].fA});
      check($sformatf("v%0d fwdBE", i),  {6'd0, fwdBE},  {6'd0, vecs[i].fB});
      check($sformatf("v%0d stallE", i), {7'd0, stallE}, 8'd0);
    end

    // Two back-to-back divides with divE held: each run spans 6 cycles.
    @(negedge clk);
    clear_inputs();
    divE = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      check_div($sformatf("div c%0d", k), (k % 6) == 0, (k % 6) >= 1 && (k % 6) <= 4,
                (k % 6) == 5, (k % 6) <= 4);
      check($sformatf("div c%0d flushE", k), {7'd0, flushE}, 8'd0);
    end
    divE = 1'b0;
    @(posedge clk);
    #1;
    check_div("div c12", 1'b0, 1'b0, 1'b0, 1'b0);

    // A divide resolving alongside a taken branch must not launch.
    @(negedge clk);
    divE = 1'b1; pcSrcE = 1'b1;
    #1;
    check_div("div+br", 1'b0, 1'b0, 1'b0, 1'b0);
    check("div+br flushD", {7'd0, flushD}, 8'd1);
    @(negedge clk);
    divE = 1'b0; pcSrcE = 1'b0;
    #1;
    check_div("div+br next", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run abandons it; a new divide starts cleanly.
    @(negedge clk);
    divE = 1'b1;
    #1;
    check("rr start", {7'd0, mdStart}, 8'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rr run2 busy", {7'd0, mdBusy}, 8'd1);
    @(negedge clk);
    rst = 1'b1; divE = 1'b0;
    #1;
    check_div("rr in rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_div("rr idle", 1'b0, 1'b0, 1'b0, 1'b0);
    divE = 1'b1;
    #1;
    check_div("rr restart", 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    divE = 1'b0;
    check_div("rr run1", 1'b0, 1'b1, 1'b0, 1'b1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (mdDone) seen = 1'b1;
      end
      check("rr done seen", {7'd0, seen}, 8'd1);
    end
    @(posedge clk); #1;
    check_div("rr after", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
